// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs MIPS instruction fields into 32-bit words and writes
//                them sequentially into instruction memory. One accept per
//                handshake, one imem write the following cycle. BEQ and J
//                targets are absolute byte addresses and are range-checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
   parameter int          ADDR_W  = 8,
   parameter logic [31:0] BASE_PC = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [31:0]       in_target,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err,
   output logic [1:0]        err_code
);

   // FSM state encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EMIT = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   // Instruction kinds
   localparam logic [3:0] K_R     = 4'd0;
   localparam logic [3:0] K_ADDI  = 4'd1;
   localparam logic [3:0] K_ADDIU = 4'd2;
   localparam logic [3:0] K_ORI   = 4'd3;
   localparam logic [3:0] K_LUI   = 4'd4;
   localparam logic [3:0] K_LW    = 4'd5;
   localparam logic [3:0] K_SW    = 4'd6;
   localparam logic [3:0] K_BEQ   = 4'd7;
   localparam logic [3:0] K_J     = 4'd8;

   // Opcodes
   localparam logic [5:0] c_OP_R     = 6'b000000;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_ADDIU = 6'b001001;
   localparam logic [5:0] c_OP_ORI   = 6'b001101;
   localparam logic [5:0] c_OP_LUI   = 6'b001111;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_J     = 6'b000010;

   // Error codes
   localparam logic [1:0] c_ERR_NONE = 2'b00;
   localparam logic [1:0] c_ERR_KIND = 2'b01;
   localparam logic [1:0] c_ERR_BEQ  = 2'b10;
   localparam logic [1:0] c_ERR_J    = 2'b11;

   // Capacity of imem in words
   localparam logic [ADDR_W:0] c_CAP = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   w_count_inc;
   logic [31:0]       r_word;
   logic              r_err;
   logic [1:0]        r_err_code;

   logic              w_accept;
   logic [31:0]       w_pc;
   logic [31:0]       w_pc4;
   logic [32:0]       w_diff;
   logic [30:0]       w_off;
   logic              w_off_ok;
   logic [31:0]       w_word;
   logic [1:0]        w_code;

   assign w_count_inc = r_count + (ADDR_W+1)'(1);
   assign w_accept    = in_valid & in_ready;

   // The branch is encoded relative to the address of the word being written
   assign w_pc   = BASE_PC + (32'(r_count) << 2);
   assign w_pc4  = w_pc + 32'd4;
   // 33-bit signed difference; pc4 is word aligned, so the low two bits of
   // the difference equal the target's low two bits (misalignment check)
   assign w_diff = {1'b0, in_target} - {1'b0, w_pc4};
   assign w_off  = w_diff[32:2];
   // Offset fits in 16 signed bits when bits [30:15] are all identical
   assign w_off_ok = (&w_off[30:15]) | ~(|w_off[30:15]);

   // Encode the presented fields and classify any error
   always_comb begin
      w_word = 32'h0;
      w_code = c_ERR_NONE;
      case (in_kind)
         K_R:     w_word = {c_OP_R, in_rs, in_rt, in_rd, in_shamt, in_funct};
         K_ADDI:  w_word = {c_OP_ADDI, in_rs, in_rt, in_imm};
         K_ADDIU: w_word = {c_OP_ADDIU, in_rs, in_rt, in_imm};
         K_ORI:   w_word = {c_OP_ORI, in_rs, in_rt, in_imm};
         K_LUI:   w_word = {c_OP_LUI, 5'd0, in_rt, in_imm};
         K_LW:    w_word = {c_OP_LW, in_rs, in_rt, in_imm};
         K_SW:    w_word = {c_OP_SW, in_rs, in_rt, in_imm};
         K_BEQ: begin
            w_word = {c_OP_BEQ, in_rs, in_rt, w_off[15:0]};
            if ((w_diff[1:0] != 2'b00) || !w_off_ok) begin
               w_code = c_ERR_BEQ;
            end
         end
         K_J: begin
            w_word = {c_OP_J, in_target[27:2]};
            if ((in_target[1:0] != 2'b00) || (in_target[31:28] != w_pc4[31:28])) begin
               w_code = c_ERR_J;
            end
         end
         default: w_code = c_ERR_KIND;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; flush overrides every state
   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept && (w_code == c_ERR_NONE)) w_next_state = S_EMIT;
            S_EMIT: w_next_state = (w_count_inc == c_CAP) ? S_FULL : S_IDLE;
            S_FULL: w_next_state = S_FULL;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      in_ready = 1'b0;
      im_we    = 1'b0;
      full     = 1'b0;
      case (r_state)
         S_IDLE: in_ready = ~flush;
         S_EMIT: im_we    = 1'b1;
         S_FULL: full     = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Datapath: encoded word, write pointer and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word     <= 32'h0;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_err_code <= c_ERR_NONE;
      end else if (flush) begin
         r_count    <= '0;
         r_err      <= 1'b0;
         r_err_code <= c_ERR_NONE;
      end else begin
         if (w_accept) begin
            if (w_code == c_ERR_NONE) begin
               r_word <= w_word;
            end else begin
               r_err      <= 1'b1;
               r_err_code <= w_code;
            end
         end
         if (r_state == S_EMIT) begin
            r_count <= w_count_inc;
         end
      end
   end

   assign im_addr  = r_count[ADDR_W-1:0];
   assign im_wdata = r_word;
   assign count    = r_count;
   assign err      = r_err;
   assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Scoreboard bench for instr_encoder (4-word imem).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
   localparam int          AW  = 2;
   localparam int          CAP = 4;
   localparam logic [31:0] BPC = 32'h0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_kind = '0;
   logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [5:0]    in_funct = '0;
   logic [15:0]   in_imm = '0;
   logic [31:0]   in_target = '0;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic [AW:0]   count;
   logic          full;
   logic          err;
   logic [1:0]    err_code;

   instr_encoder #(.ADDR_W(AW), .BASE_PC(BPC)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .count(count),
      .full(full), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } exp_t;
   exp_t sb[$];

   int         m_count = 0;
   bit         m_err = 1'b0;
   logic [1:0] m_code = 2'b00;
   int         n_checks = 0;
   int         n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference encoder from the instruction-format rules
   function automatic void model(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [15:0] imm, input logic [31:0] tgt, input int cnt,
                                 output logic [1:0] code, output logic [31:0] w);
      longint     pc4;
      longint     diff;
      longint     off;
      logic [63:0] ov;
      pc4  = (longint'(BPC) + 4 * cnt + 4) & 64'hFFFF_FFFF;
      code = 2'b00;
      w    = 32'h0;
      case (k)
         4'd0: w = {6'b000000, rs, rt, rd, sh, fn};
         4'd1: w = {6'b001000, rs, rt, imm};
         4'd2: w = {6'b001001, rs, rt, imm};
         4'd3: w = {6'b001101, rs, rt, imm};
         4'd4: w = {6'b001111, 5'd0, rt, imm};
         4'd5: w = {6'b100011, rs, rt, imm};
         4'd6: w = {6'b101011, rs, rt, imm};
         4'd7: begin
            diff = longint'(tgt) - pc4;
            off  = diff / 4;
            ov   = off;
            if ((tgt % 4) != 0 || off < -32768 || off > 32767) code = 2'b10;
            else w = {6'b000100, rs, rt, ov[15:0]};
         end
         4'd8: begin
            if ((tgt % 4) != 0 || (tgt / 32'h1000_0000) != (pc4 / 64'h1000_0000)) code = 2'b11;
            else w = {6'b000010, 26'(tgt / 4)};
         end
         default: code = 2'b01;
      endcase
   endfunction

   task automatic check_status(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(m_count));
      chk({tag, ".full"}, 32'(full), 32'(m_count == CAP));
      chk({tag, ".err"}, 32'(err), 32'(m_err));
      chk({tag, ".err_code"}, 32'(err_code), 32'(m_code));
   endtask

   task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [31:0] tgt);
      in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      in_funct = fn; in_imm = imm; in_target = tgt; in_valid = 1'b1;
   endtask

   // Issue one instruction (called #1 after a rising edge); use_lit forces a
   // literal expected word for the directed vectors
   task automatic send(input string tag, input logic [3:0] k, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm, input logic [31:0] tgt,
                       input bit use_lit, input logic [31:0] lit);
      bit         rdy;
      logic [1:0] code;
      logic [31:0] w;
      rdy = (m_count < CAP);
      drive(k, rs, rt, rd, sh, fn, imm, tgt);
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      model(k, rs, rt, rd, sh, fn, imm, tgt, m_count, code, w);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (rdy) begin
         if (code == 2'b00) begin
            sb.push_back('{a: AW'(m_count), d: (use_lit ? lit : w)});
            @(posedge clk); #1;
            m_count++;
         end else begin
            m_err  = 1'b1;
            m_code = code;
         end
      end
      check_status(tag);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      #1;
      chk("flush.in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      flush = 1'b0;
      m_count = 0; m_err = 1'b0; m_code = 2'b00;
      check_status("flush");
   endtask

   // Legal accept followed by flush during the write cycle
   task automatic flush_in_emit(input logic [15:0] imm);
      logic [1:0]  code;
      logic [31:0] w;
      drive(4'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, imm, 32'h0);
      model(4'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, imm, 32'h0, m_count, code, w);
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush = 1'b1;
      sb.push_back('{a: AW'(m_count), d: w});
      @(posedge clk); #1;
      flush = 1'b0;
      m_count = 0; m_err = 1'b0; m_code = 2'b00;
      check_status("flush_emit");
   endtask

   // Monitor: every imem write must match the oldest expected word
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", im_addr, im_wdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("write.addr", 32'(im_addr), 32'(e.a));
            chk("write.data", im_wdata, e.d);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.im_we", 32'(im_we), 32'h0);
      chk("rst.im_addr", 32'(im_addr), 32'h0);
      chk("rst.im_wdata", im_wdata, 32'h0);
      check_status("rst");
      rst = 1'b0;
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;

      send("addiu", 4'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd5, 32'h0, 1'b1, 32'h2509_0005);
      do_flush();
      send("r",   4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 32'h0, 1'b1, 32'h0022_1821);
      send("lw",  4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd4, 32'h0, 1'b1, 32'h8C22_0004);
      send("beq", 4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0, 1'b1, 32'h1022_FFFD);
      send("j",   4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h40, 1'b1, 32'h0800_0010);
      send("fifth", 4'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 32'h0, 1'b0, 32'h0);
      do_flush();

      send("beq_far", 4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0004_0000, 1'b0, 32'h0);
      send("kind12", 4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0, 1'b0, 32'h0);
      send("j_region", 4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h1000_0000, 1'b0, 32'h0);
      send("beq_max", 4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0002_0000, 1'b1, 32'h1064_7FFF);
      send("beq_over", 4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0002_0008, 1'b0, 32'h0);
      send("beq_mis", 4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0000_0022, 1'b0, 32'h0);
      send("lui", 4'd4, 5'd7, 5'd6, 5'd0, 5'd0, 6'd0, 16'hBEEF, 32'h0, 1'b1, 32'h3C06_BEEF);
      do_flush();
      flush_in_emit(16'h1234);

      // Reset during the write cycle drops the strobe immediately
      drive(4'd6, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h10, 32'h0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("rst_emit.im_we", 32'(im_we), 32'h0);
      chk("rst_emit.im_wdata", im_wdata, 32'h0);
      m_count = 0; m_err = 1'b0; m_code = 2'b00;
      check_status("rst_emit");
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_emit.in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         int          r;
         logic [3:0]  k;
         logic [31:0] tgt;
         longint      pc4;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            do_flush();
         end else if (r == 1 && m_count < CAP) begin
            flush_in_emit(16'($urandom));
         end else begin
            k = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            pc4 = longint'(BPC) + 4 * m_count + 4;
            case ($urandom_range(0, 3))
               0: tgt = $urandom;
               1: tgt = 32'(pc4 + 4 * longint'($urandom_range(0, 33000)) - 4 * 300);
               2: tgt = 32'(pc4 + 4 * longint'($urandom_range(32760, 32775)));
               default: tgt = 32'($urandom_range(0, 255));
            endcase
            send("rand", k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 6'($urandom), 16'($urandom), tgt, 1'b0, 32'h0);
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
